// File: rtl/alu_pipe.sv
// Registered ARM data-processing ALU with NZCV flags and valid/ready handshakes.
// Define ALU_PIPE_MUL_EN to enable the iterative MUL (opcode 1011); otherwise 1011 is illegal.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] OP_X,
  input  logic [WIDTH-1:0] OP_Y,
  input  logic [3:0]       ALU_CTRL,
  input  logic             SET_FLAGS,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       NZCV,
  output logic             OUT_ERR
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_ORR = 4'b0011,
    OP_EOR = 4'b0100, OP_BIC = 4'b0101, OP_MOV = 4'b0110, OP_MVN = 4'b0111,
    OP_ADC = 4'b1000, OP_SBC = 4'b1001, OP_RSB = 4'b1010, OP_MUL = 4'b1011
  } op_e;

  if (WIDTH < 8 || (1 << CNT_W) <= WIDTH) begin : g_param_check
    $error("alu_pipe: WIDTH must be >= 8 and 2**CNT_W must exceed WIDTH");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic             out_err_q, out_err_d;

  logic             slot_free, accept, is_mul;
  logic [WIDTH-1:0] add_a, add_b, res;
  logic             add_cin, arith, err;
  logic [WIDTH:0]   sum;
  logic             flag_c, flag_v;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
  logic [WIDTH-1:0] acc_step, mul_res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_sf_q, mul_sf_d, mul_load;

  assign is_mul   = (ALU_CTRL == OP_MUL);
  assign IN_READY = (state_q == S_IDLE) && slot_free;
`else
  assign is_mul   = 1'b0;
  assign IN_READY = slot_free;
`endif

  assign slot_free = !out_valid_q || OUT_READY;
  assign accept    = IN_VALID && IN_READY;

  // Single-cycle datapath: every arithmetic op maps onto one WIDTH+1 adder.
  always_comb begin
    add_a   = OP_X;
    add_b   = OP_Y;
    add_cin = 1'b0;
    arith   = 1'b0;
    err     = 1'b0;
    res     = '0;
    case (ALU_CTRL)
      OP_ADD: arith = 1'b1;
      OP_SUB: begin add_b = ~OP_Y; add_cin = 1'b1; arith = 1'b1; end
      OP_AND: res = OP_X & OP_Y;
      OP_ORR: res = OP_X | OP_Y;
      OP_EOR: res = OP_X ^ OP_Y;
      OP_BIC: res = OP_X & ~OP_Y;
      OP_MOV: res = OP_Y;
      OP_MVN: res = ~OP_Y;
      OP_ADC: begin add_cin = nzcv_q[1]; arith = 1'b1; end
      OP_SBC: begin add_b = ~OP_Y; add_cin = nzcv_q[1]; arith = 1'b1; end
      OP_RSB: begin add_a = OP_Y; add_b = ~OP_X; add_cin = 1'b1; arith = 1'b1; end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: res = '0;
`endif
      default: err = 1'b1;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    if (arith) res = sum[WIDTH-1:0];
    flag_c = arith ? sum[WIDTH] : nzcv_q[1];
    flag_v = arith ? ((add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]))
                   : nzcv_q[0];
  end

`ifdef ALU_PIPE_MUL_EN
  // Shift-add multiplier; the final iteration loads straight into the output slot when it is free.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_sf_d = mul_sf_q;
    mul_load = 1'b0;
    mul_res  = acc_q;
    acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: if (accept && is_mul) begin
        state_d  = S_MUL;
        mcand_d  = OP_X;
        mplr_d   = OP_Y;
        acc_d    = '0;
        cnt_d    = '0;
        mul_sf_d = SET_FLAGS;
      end
      S_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          if (slot_free) begin
            mul_load = 1'b1;
            mul_res  = acc_step;
            state_d  = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: if (slot_free) begin
        mul_load = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q && !OUT_READY;
    alu_out_d   = alu_out_q;
    out_err_d   = out_err_q;
    nzcv_d      = nzcv_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      alu_out_d   = res;
      out_err_d   = err;
      if (SET_FLAGS && !err) nzcv_d = {res[WIDTH-1], res == '0, flag_c, flag_v};
    end
`ifdef ALU_PIPE_MUL_EN
    if (mul_load) begin
      out_valid_d = 1'b1;
      alu_out_d   = mul_res;
      out_err_d   = 1'b0;
      if (mul_sf_q) nzcv_d = {mul_res[WIDTH-1], mul_res == '0, nzcv_q[1:0]};
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      nzcv_q      <= '0;
      out_err_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_sf_q    <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      nzcv_q      <= nzcv_d;
      out_err_q   <= out_err_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_sf_q    <= mul_sf_d;
`endif
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = alu_out_q;
  assign NZCV      = nzcv_q;
  assign OUT_ERR   = out_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32); MUL expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] OP_X, OP_Y;
  logic [3:0]  ALU_CTRL;
  logic        SET_FLAGS;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] ALU_OUT;
  logic [3:0]  NZCV;
  logic        OUT_ERR;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_X(OP_X), .OP_Y(OP_Y), .ALU_CTRL(ALU_CTRL), .SET_FLAGS(SET_FLAGS),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ALU_OUT(ALU_OUT),
    .NZCV(NZCV), .OUT_ERR(OUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one beat from #1 after an edge, expects acceptance and a 1-cycle result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic sf, input logic [31:0] exp_out,
                        input logic [3:0] exp_nzcv, input logic exp_err);
    ALU_CTRL = op; OP_X = x; OP_Y = y; SET_FLAGS = sf; IN_VALID = 1'b1;
    #1;
    check({tag, ".in_ready"}, IN_READY, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check({tag, ".valid"}, OUT_VALID, 1'b1);
    check({tag, ".out"}, ALU_OUT, exp_out);
    check({tag, ".nzcv"}, NZCV, exp_nzcv);
    check({tag, ".err"}, OUT_ERR, exp_err);
  endtask

  initial begin
    int n;
    int bad;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OP_X = '0; OP_Y = '0; ALU_CTRL = '0; SET_FLAGS = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.valid", OUT_VALID, 1'b0);
    check("rst.out", ALU_OUT, 32'h0);
    check("rst.nzcv", NZCV, 4'h0);
    check("rst.err", OUT_ERR, 1'b0);
    RST = 1'b0;
    #1;
    check("rst.in_ready", IN_READY, 1'b1);
    @(posedge CLK); #1;

    run_op("add_big", 4'b0000, 32'hFF000000, 32'hF0000000, 1'b1, 32'hEF000000, 4'b1010, 1'b0);
    run_op("and",     4'b0010, 32'hFF000000, 32'hF0000000, 1'b1, 32'hF0000000, 4'b1010, 1'b0);
    run_op("eor",     4'b0100, 32'hFF000000, 32'hF0000000, 1'b1, 32'h0F000000, 4'b0010, 1'b0);
    run_op("orr",     4'b0011, 32'hFF000000, 32'hF0000000, 1'b1, 32'hFF000000, 4'b1010, 1'b0);
    run_op("sub_eq",  4'b0001, 32'h5,        32'h5,        1'b1, 32'h0,        4'b0110, 1'b0);
    run_op("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1,        1'b1, 32'h80000000, 4'b1001, 1'b0);
    run_op("sbc_c0",  4'b1001, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 4'b1000, 1'b0);
    run_op("add_nsf", 4'b0000, 32'h1,        32'h2,        1'b0, 32'h3,        4'b1000, 1'b0);
    run_op("bic",     4'b0101, 32'hFFFF00FF, 32'h0000FFFF, 1'b1, 32'hFFFF0000, 4'b1000, 1'b0);
    run_op("mov0",    4'b0110, 32'h12345678, 32'h0,        1'b1, 32'h0,        4'b0100, 1'b0);
    run_op("mvn0",    4'b0111, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 4'b1000, 1'b0);
    run_op("rsb",     4'b1010, 32'h1,        32'h3,        1'b1, 32'h2,        4'b0010, 1'b0);
    run_op("adc_c1",  4'b1000, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        4'b0110, 1'b0);
    run_op("illegal", 4'b1110, 32'h1,        32'h1,        1'b1, 32'h0,        4'b0110, 1'b1);
    run_op("sub_neg", 4'b0001, 32'h3,        32'h5,        1'b1, 32'hFFFFFFFE, 4'b1000, 1'b0);
    run_op("add_clr", 4'b0000, 32'h1,        32'h2,        1'b0, 32'h3,        4'b1000, 1'b0);

    // Backpressure: one slot, second beat waits until the first drains.
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    run_op("bp1", 4'b0000, 32'd10, 32'd20, 1'b0, 32'd30, 4'b1000, 1'b0);
    check("bp.stall_ready", IN_READY, 1'b0);
    ALU_CTRL = 4'b0000; OP_X = 32'h100; OP_Y = 32'h200; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    check("bp.hold_valid", OUT_VALID, 1'b1);
    check("bp.hold_out", ALU_OUT, 32'd30);
    check("bp.hold_ready", IN_READY, 1'b0);
    OUT_READY = 1'b1;
    #1;
    check("bp.pass_ready", IN_READY, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check("bp2.valid", OUT_VALID, 1'b1);
    check("bp2.out", ALU_OUT, 32'h300);
    @(posedge CLK); #1;
    check("bp.drained", OUT_VALID, 1'b0);

    run_op("sub_pre", 4'b0001, 32'h5, 32'h5, 1'b1, 32'h0, 4'b0110, 1'b0);
`ifdef ALU_PIPE_MUL_EN
    ALU_CTRL = 4'b1011; OP_X = 32'h00010003; OP_Y = 32'h5; SET_FLAGS = 1'b1; IN_VALID = 1'b1;
    #1;
    check("mul.in_ready", IN_READY, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n = 0; bad = 0;
    while (!OUT_VALID && n < 100) begin
      if (IN_READY !== 1'b0) bad++;
      @(posedge CLK); #1;
      n++;
    end
    check("mul.latency", n, 32);
    check("mul.busy_ready", bad, 0);
    check("mul.out", ALU_OUT, 32'h0005000F);
    check("mul.nzcv", NZCV, 4'b0010);
    check("mul.err", OUT_ERR, 1'b0);
    @(posedge CLK); #1;
    ALU_CTRL = 4'b1011; OP_X = 32'h7; OP_Y = 32'h9; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
`else
    run_op("mul_ill", 4'b1011, 32'h00010003, 32'h5, 1'b1, 32'h0, 4'b0110, 1'b1);
    @(posedge CLK); #1;
`endif
    // Asynchronous reset pulse between edges.
    #1 RST = 1'b1;
    #2;
    check("rst2.valid", OUT_VALID, 1'b0);
    check("rst2.nzcv", NZCV, 4'h0);
    RST = 1'b0;
    #1;
    check("rst2.in_ready", IN_READY, 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0) bad++;
    end
    check("rst2.nothing_out", bad, 0);
    run_op("add_post", 4'b0000, 32'h1, 32'h2, 1'b1, 32'h3, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU in the ARM datapath.
- Generalises operand width and widens the op set to a 4-bit encoded ARM data-processing subset, including ADC/SBC/RSB/BIC/MVN.
- Keeps a persistent NZCV flag register with S-bit style conditional update.
- Adds valid/ready handshakes on both sides and an optional multi-cycle iterative multiplier; sits between the decode/register-read stage and writeback.

Parameters:
- WIDTH, 32: operand/result width in bits (minimum 8).
- CNT_W, 6: multiply iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand/op beat offered.
- IN_READY  output  1  block accepts the beat this cycle.
- OP_X  input  WIDTH  first operand (Rn).
- OP_Y  input  WIDTH  second operand (Op2).
- ALU_CTRL  input  4  operation code.
- SET_FLAGS  input  1  update NZCV with this op's flags.
- OUT_VALID  output  1  result register holds an undelivered result.
- OUT_READY  input  1  consumer takes the result this cycle.
- ALU_OUT  output  WIDTH  registered result.
- NZCV  output  4  flag register {N,Z,C,V}.
- OUT_ERR  output  1  delivered result came from an illegal/unsupported opcode.

Behaviour:
- Reset (async, RST=1): state=IDLE, OUT_VALID=0, ALU_OUT=0, NZCV=0000, OUT_ERR=0, multiply registers and counter cleared. An in-flight multiply is discarded.
- Opcodes:
  - 0000 ADD X+Y; 0001 SUB X-Y; 0010 AND; 0011 ORR; 0100 EOR; 0101 BIC X&~Y.
  - 0110 MOV Y; 0111 MVN ~Y.
  - 1000 ADC X+Y+C; 1001 SBC X+~Y+C; 1010 RSB Y-X; 1011 MUL (low WIDTH bits of X*Y).
  - 1100-1111 illegal.
- Arithmetic is performed at WIDTH+1 bits.
  - C = carry out; for SUB/SBC/RSB, C=1 means no borrow (ARM convention).
  - V = signed overflow: operand MSBs equal and result MSB differs, applied to the effective adder inputs.
- Logical ops, MOV, MVN and MUL compute N=MSB and Z=(result==0); C and V keep their previous values.
- ADC/SBC use the NZCV register's C as it stands at the acceptance edge.
- Flag commit: NZCV is written only when SET_FLAGS=1, at the same edge the result is loaded into ALU_OUT. SET_FLAGS=0 leaves NZCV unchanged.
- Illegal op: ALU_OUT=0, OUT_ERR=1, NZCV unchanged regardless of SET_FLAGS; delivered with single-cycle latency.
- Handshake:
  - Transfer in = IN_VALID&IN_READY; transfer out = OUT_VALID&OUT_READY.
  - IN_READY = (state==IDLE) & (!OUT_VALID | OUT_READY), i.e. one result slot with same-cycle pass-through on drain.
  - ALU_OUT, OUT_ERR and OUT_VALID hold stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID clears after a transfer out unless a new result loads on the same edge.
- Single-cycle ops: result, OUT_ERR and flags load on the acceptance edge; OUT_VALID=1 in the following cycle (latency 1). Full throughput of 1 op/cycle is sustained when OUT_READY=1.
- State machine (MUL only):
  - IDLE -> MUL on acceptance of op 1011. Load multiplicand=X, multiplier=Y, accumulator=0, counter=0.
  - MUL: each cycle, if multiplier LSB is 1 then add the multiplicand to the accumulator; shift multiplicand left and multiplier right; counter+1. Stay until counter==WIDTH-1 has been processed.
  - End of MUL: if the output slot is free or draining, load the result and go to IDLE; otherwise go to DONE.
  - DONE: wait until the slot is free or draining, load the result, go to IDLE.
  - IN_READY=0 throughout MUL and DONE.
- MUL latency is WIDTH clock edges from acceptance to OUT_VALID=1 when there is no backpressure. The product is truncated to WIDTH bits.
- Simultaneous events: IN_VALID is ignored while IN_READY=0. Deassertion of OUT_READY mid-MUL only delays the result load. Reset asserted during MUL or DONE returns to IDLE with nothing delivered.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 1011 runs the iterative multiplier as above.
- Undefined: the multiplier datapath, counter and MUL/DONE states are absent. 1011 is treated as illegal (ALU_OUT=0, OUT_ERR=1, latency 1), and IN_READY depends only on the output slot.

Test Plan:
- WIDTH=32, SET_FLAGS=1, OUT_READY=1: X=FF000000, Y=F0000000 ADD -> ALU_OUT=EF000000, NZCV=1010. Then AND -> F0000000, NZCV=1010 (C,V kept). Then EOR -> 0F000000, NZCV=0010. Then ORR -> FF000000, NZCV=1010.
- SUB 5-5 -> 00000000, NZCV=0110.
  - ADD 7FFFFFFF+00000001 -> 80000000, NZCV=1001.
  - Following SBC 0-0 with C=0 -> FFFFFFFF, NZCV=1000.
  - ADD with SET_FLAGS=0 -> NZCV unchanged.
- Backpressure: OUT_READY=0, two back-to-back ADDs offered -> first accepted, IN_READY=0 next cycle, ALU_OUT held. Raise OUT_READY -> first delivered and second accepted on the same edge, then delivered one cycle later.
- With macro defined: MUL 00010003*00000005 -> 0005000F, OUT_VALID exactly 32 edges after acceptance, IN_READY=0 meanwhile. Without macro: same stimulus -> ALU_OUT=0, OUT_ERR=1 after 1 cycle.
- Illegal opcode 1110 with SET_FLAGS=1 -> ALU_OUT=0, OUT_ERR=1, NZCV unchanged.
- Pulse RST at MUL iteration 10 -> OUT_VALID=0, NZCV=0000, IN_READY=1 after release; the next ADD 1+2 -> 00000003.
